cosim_commit_sched: RTL and testbench

Commit scheduler sitting between a dual-retire core pipeline and the co-simulation checker. It accepts up to two retired-instruction records per cycle in program order and buffers them. It drains exactly one record per cycle onto the single-lane checker port (valid/pc/inst/we/rd/wdata). On a checker error it freezes the stream and latches the failing PC for the testbench.

---
 rtl/cosim_pkg.sv | 18 +
 rtl/cosim_commit_fifo.sv | 46 ++++
 rtl/cosim_commit_sched.sv | 109 ++++++++++
 tb/tb_cosim_commit_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_pkg.sv
// Shared types for the co-simulation commit scheduler.
// Retired-instruction record and scheduler state encoding.
package cosim_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } commit_rec_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/cosim_commit_fifo.sv
// Two-write / one-read circular FIFO of commit records.
// wr0/wr1 write slots wp and wp+1; rd pops head; count = fill.
module cosim_commit_fifo
  import cosim_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr0_en,
  input  commit_rec_t            wr0_data,
  input  logic                   wr1_en,
  input  commit_rec_t            wr1_data,
  input  logic                   rd_en,
  output commit_rec_t            head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  commit_rec_t   mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  assign head = mem[rp];

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wp] <= wr0_data;
    if (wr1_en) mem[wp + PW'(1)] <= wr1_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + PW'(wr0_en) + PW'(wr1_en);
      rp    <= rp + PW'(rd_en);
      count <= count + CW'(wr0_en) + CW'(wr1_en)
               - CW'(rd_en);
    end
  end

endmodule

// File: rtl/cosim_commit_sched.sv
// Dual-retire to single-lane commit scheduler for cosim.
// in0/in1 retire lanes in, cosim_* checker lane out, halt on chk_error.
module cosim_commit_sched
  import cosim_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in0_valid,
  input  logic [63:0]            in0_pc,
  input  logic [31:0]            in0_inst,
  input  logic                   in0_we,
  input  logic [4:0]             in0_rd,
  input  logic [63:0]            in0_wdata,
  input  logic                   in1_valid,
  input  logic [63:0]            in1_pc,
  input  logic [31:0]            in1_inst,
  input  logic                   in1_we,
  input  logic [4:0]             in1_rd,
  input  logic [63:0]            in1_wdata,
  output logic                   in_ready,
  input  logic                   pause,
  output logic                   cosim_valid,
  output logic [63:0]            cosim_pc,
  output logic [31:0]            cosim_inst,
  output logic                   cosim_we,
  output logic [4:0]             cosim_rd,
  output logic [63:0]            cosim_wdate,
  input  logic                   chk_error,
  output logic                   halted,
  output logic [63:0]            halted_pc,
  output logic [63:0]            commit_cnt,
  output logic                   proto_err,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_t state;
  commit_rec_t  rec0;
  commit_rec_t  rec1;
  commit_rec_t  head;
  logic [63:0]  last_pc;
  logic         wr0;
  logic         wr1;
  logic         empty;

  // x0 writes are architecturally dead; hide them from the checker.
  assign rec0 = '{pc: in0_pc, inst: in0_inst,
                  we: in0_we & (in0_rd != 5'd0),
                  rd: in0_rd, wdata: in0_wdata};
  assign rec1 = '{pc: in1_pc, inst: in1_inst,
                  we: in1_we & (in1_rd != 5'd0),
                  rd: in1_rd, wdata: in1_wdata};

  // Ready ignores a same-cycle pop so it never depends on pause.
  assign in_ready = (state == RUN)
                  && (occupancy <= CW'(DEPTH - 2));
  assign wr0   = in_ready & in0_valid;
  assign wr1   = wr0 & in1_valid;
  assign empty = (occupancy == '0);

  assign cosim_valid = ~empty & (state == RUN)
                     & ~pause & ~chk_error;

  assign cosim_pc    = head.pc;
  assign cosim_inst  = head.inst;
  assign cosim_we    = head.we;
  assign cosim_rd    = head.rd;
  assign cosim_wdate = head.wdata;
  assign halted      = (state == HALT);

  cosim_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (wr0),
    .wr0_data (rec0),
    .wr1_en   (wr1),
    .wr1_data (rec1),
    .rd_en    (cosim_valid),
    .head     (head),
    .count    (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      halted_pc  <= '0;
      last_pc    <= '0;
      commit_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (in1_valid & ~in0_valid) proto_err <= 1'b1;
      if (cosim_valid) begin
        commit_cnt <= commit_cnt + 64'd1;
        last_pc    <= head.pc;
      end
      unique case (state)
        RUN: if (chk_error) begin
          state     <= HALT;
          halted_pc <= last_pc;
        end
        HALT: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cosim_commit_sched.sv
// Directed, table-driven bench for cosim_commit_sched.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_cosim_commit_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in0_valid = 0, in1_valid = 0;
  logic [63:0] in0_pc = 0, in1_pc = 0;
  logic [31:0] in0_inst = 0, in1_inst = 0;
  logic        in0_we = 0, in1_we = 0;
  logic [4:0]  in0_rd = 0, in1_rd = 0;
  logic [63:0] in0_wdata = 0, in1_wdata = 0;
  logic        pause = 0, chk_error = 0;
  logic        in_ready, cosim_valid, cosim_we;
  logic [63:0] cosim_pc, cosim_wdate;
  logic [31:0] cosim_inst;
  logic [4:0]  cosim_rd;
  logic        halted, proto_err;
  logic [63:0] halted_pc, commit_cnt;
  logic [3:0]  occupancy;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  cosim_commit_sched #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_pc(in0_pc),
    .in0_inst(in0_inst), .in0_we(in0_we),
    .in0_rd(in0_rd), .in0_wdata(in0_wdata),
    .in1_valid(in1_valid), .in1_pc(in1_pc),
    .in1_inst(in1_inst), .in1_we(in1_we),
    .in1_rd(in1_rd), .in1_wdata(in1_wdata),
    .in_ready(in_ready), .pause(pause),
    .cosim_valid(cosim_valid), .cosim_pc(cosim_pc),
    .cosim_inst(cosim_inst), .cosim_we(cosim_we),
    .cosim_rd(cosim_rd), .cosim_wdate(cosim_wdate),
    .chk_error(chk_error), .halted(halted),
    .halted_pc(halted_pc), .commit_cnt(commit_cnt),
    .proto_err(proto_err), .occupancy(occupancy)
  );

  typedef struct {
    logic        v0, v1;
    logic [63:0] pc0, pc1;
    logic        pz;
    logic        rdy, cv;
    logic [63:0] pc;
    logic [3:0]  occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic v0, logic v1, logic [63:0] pc0, logic [63:0] pc1,
    logic pz, logic rdy, logic cv, logic [63:0] pc,
    logic [3:0] occ);
    vec_t r;
    r.v0 = v0; r.v1 = v1; r.pc0 = pc0; r.pc1 = pc1;
    r.pz = pz; r.rdy = rdy; r.cv = cv; r.pc = pc;
    r.occ = occ;
    return r;
  endfunction

  function automatic logic [31:0] inst_of(logic [63:0] pc);
    return pc[31:0] ^ 32'h0000_0013;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v0, logic v1, logic [63:0] pc0,
                       logic [63:0] pc1, logic pz);
    in0_valid = v0; in0_pc = pc0; in0_inst = inst_of(pc0);
    in0_we = 1'b1; in0_rd = 5'd7; in0_wdata = ~pc0;
    in1_valid = v1; in1_pc = pc1; in1_inst = inst_of(pc1);
    in1_we = 1'b1; in1_rd = 5'd7; in1_wdata = ~pc1;
    pause = pz;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    chk_error = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".cosim_valid"}, 64'(cosim_valid), 64'd0);
    chk({tag, ".halted"}, 64'(halted), 64'd0);
    chk({tag, ".halted_pc"}, halted_pc, 64'd0);
    chk({tag, ".commit_cnt"}, commit_cnt, 64'd0);
    chk({tag, ".proto_err"}, 64'(proto_err), 64'd0);
    chk({tag, ".occupancy"}, 64'(occupancy), 64'd0);
  endtask

  initial begin
    // pc0 pc1 pause | ready valid pc occ
    tbl.push_back(mk(1,1,'h100,'h104,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h100,2));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h104,1));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,1,'h1000,'h1004,1, 1,0,0,0));
    tbl.push_back(mk(1,1,'h1008,'h100c,1, 1,0,0,2));
    tbl.push_back(mk(1,1,'h1010,'h1014,1, 1,0,0,4));
    tbl.push_back(mk(1,1,'h1018,'h101c,1, 1,0,0,6));
    tbl.push_back(mk(1,1,'h5000,'h5004,1, 0,0,0,8));
    tbl.push_back(mk(0,0,0,0,0, 0,1,'h1000,8));
    tbl.push_back(mk(1,0,'h9999,0,0, 0,1,'h1004,7));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h1008,6));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h100c,5));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h1010,4));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h1014,3));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h1018,2));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h101c,1));
    tbl.push_back(mk(1,0,'h2000,0,0, 1,0,0,0));
    tbl.push_back(mk(1,1,'h2004,'h2008,0, 1,1,'h2000,1));
    tbl.push_back(mk(1,1,'h200c,'h2010,0, 1,1,'h2004,2));
    tbl.push_back(mk(1,1,'h2014,'h2018,0, 1,1,'h2008,3));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h200c,4));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h2010,3));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h2014,2));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h2018,1));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,0));

    do_reset();
    chk_reset_vals("reset");

    // single lane, exact fields
    @(negedge clk);
    in0_valid = 1; in0_pc = 64'h8000_0000;
    in0_inst = 32'h0010_0093; in0_we = 1;
    in0_rd = 5'd1; in0_wdata = 64'd1;
    #1 chk("single.pre_valid", 64'(cosim_valid), 64'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("single.valid", 64'(cosim_valid), 64'd1);
    chk("single.pc", cosim_pc, 64'h8000_0000);
    chk("single.inst", 64'(cosim_inst), 64'h0010_0093);
    chk("single.we", 64'(cosim_we), 64'd1);
    chk("single.rd", 64'(cosim_rd), 64'd1);
    chk("single.wdata", cosim_wdate, 64'd1);
    @(negedge clk); #1;
    chk("single.post_valid", 64'(cosim_valid), 64'd0);
    chk("single.cnt", commit_cnt, 64'd1);

    // dual lane, fill, full, wrap, streaming
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].v0, tbl[i].v1, tbl[i].pc0, tbl[i].pc1,
            tbl[i].pz);
      #1;
      chk($sformatf("v%0d.in_ready", i), 64'(in_ready),
          64'(tbl[i].rdy));
      chk($sformatf("v%0d.valid", i), 64'(cosim_valid),
          64'(tbl[i].cv));
      chk($sformatf("v%0d.occ", i), 64'(occupancy),
          64'(tbl[i].occ));
      if (tbl[i].cv) begin
        chk($sformatf("v%0d.pc", i), cosim_pc, tbl[i].pc);
        chk($sformatf("v%0d.inst", i), 64'(cosim_inst),
            64'(inst_of(tbl[i].pc)));
        chk($sformatf("v%0d.wdata", i), cosim_wdate,
            ~tbl[i].pc);
      end
    end
    chk("table.cnt", commit_cnt, 64'd18);

    // rd==0 suppression
    @(negedge clk);
    in0_valid = 1; in0_pc = 64'h300; in0_inst = 32'h13;
    in0_we = 1; in0_rd = 5'd0; in0_wdata = 64'hdead;
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rd0.valid", 64'(cosim_valid), 64'd1);
    chk("rd0.pc", cosim_pc, 64'h300);
    chk("rd0.we", 64'(cosim_we), 64'd0);
    chk("rd0.wdata", cosim_wdate, 64'hdead);
    @(negedge clk); #1;
    chk("rd0.cnt", commit_cnt, 64'd19);

    // protocol error
    chk("proto.pre", 64'(proto_err), 64'd0);
    @(negedge clk);
    drive(0, 1, 0, 64'h400, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("proto.set", 64'(proto_err), 64'd1);
    chk("proto.occ", 64'(occupancy), 64'd0);
    chk("proto.valid", 64'(cosim_valid), 64'd0);
    @(negedge clk); #1;
    chk("proto.sticky", 64'(proto_err), 64'd1);
    do_reset();
    chk_reset_vals("reset2");

    // checker error
    @(negedge clk);
    drive(1, 1, 64'h200, 64'h204, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("err.first_valid", 64'(cosim_valid), 64'd1);
    chk("err.first_pc", cosim_pc, 64'h200);
    @(negedge clk);
    chk_error = 1;
    #1;
    chk("err.blocked", 64'(cosim_valid), 64'd0);
    chk("err.head_pc", cosim_pc, 64'h204);
    @(negedge clk);
    drive(1, 0, 64'h208, 0, 0);
    #1;
    chk("err.halted", 64'(halted), 64'd1);
    chk("err.halted_pc", halted_pc, 64'h200);
    chk("err.in_ready", 64'(in_ready), 64'd0);
    chk("err.valid", 64'(cosim_valid), 64'd0);
    chk("err.cnt", commit_cnt, 64'd1);
    @(negedge clk);
    chk_error = 0;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("err.stay_halted", 64'(halted), 64'd1);
    chk("err.stay_invalid", 64'(cosim_valid), 64'd0);
    chk("err.frozen_occ", 64'(occupancy), 64'd1);
    do_reset();
    chk_reset_vals("reset3");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
